// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream mux, round-robin or fixed-priority, registered output, optional packet lock (d/d_valid/d_last in, d_ready out; y/y_valid/y_last/y_sel out, y_ready in)
module stream_mux_rr #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 4,
  parameter int RR_MODE = 1,
  parameter int PACKET_LOCK = 1,
  localparam int SELW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       d_valid,
  output logic [CHANNELS-1:0]       d_ready,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       d_last,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      y_last,
  output logic [SELW-1:0]           y_sel
);
  typedef enum logic {ARB, LOCK} state_t;
  state_t state, state_n;
  logic [SELW-1:0] ptr, ptr_n, lch, lch_n, g;
  logic found, acc;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ARB;
      ptr <= '0;
      lch <= '0;
      y_valid <= 1'b0;
      y <= '0;
      y_last <= 1'b0;
      y_sel <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      lch <= lch_n;
      if (acc) begin
        y_valid <= 1'b1;
        y <= d[int'(g)*WIDTH +: WIDTH];
        y_last <= d_last[g];
        y_sel <= g;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end
  always_comb begin
    found = 1'b0;
    g = '0;
    if (state == LOCK) begin
      found = d_valid[lch];
      g = lch;
    end else begin
      for (int k = 0; k < CHANNELS; k++)
        if (!found && d_valid[(int'(ptr) + k) % CHANNELS]) begin
          found = 1'b1;
          g = SELW'((int'(ptr) + k) % CHANNELS);
        end
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    lch_n = lch;
    if (acc) begin
      if (PACKET_LOCK != 0 && !d_last[g]) begin
        state_n = LOCK;
        lch_n = g;
      end else begin
        state_n = ARB;
        ptr_n = (RR_MODE == 0 || int'(g) == CHANNELS - 1) ? '0 : g + 1'b1;
      end
    end
  end
  always_comb begin
    acc = reset_n && enable && found && (!y_valid || y_ready);
    d_ready = CHANNELS'(acc) << g;
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: table vectors, directed corner sequences and a randomized model check for stream_mux_rr
module tb_stream_mux_rr;
  logic clock = 1'b0;
  logic rst_n, en, yr;
  logic [3:0] dv, dl;
  logic [31:0] dat [4];
  logic [127:0] d;
  logic [3:0] d_ready, d_ready_fp;
  logic y_valid, y_last, y_valid_fp, y_last_fp;
  logic [31:0] y, y_fp;
  logic [1:0] y_sel, y_sel_fp;
  int total = 0, bad = 0;
  int m_lock, m_ptr, m_ys;
  bit m_yv, m_yl;
  logic [31:0] m_y;
  logic [3:0] s_ready, s_rfp;
  logic s_yv;
  logic [1:0] s_ys;
  logic [31:0] s_y;
  typedef struct {
    logic rst_n, en, yr;
    logic [3:0] dv, dl, er;
    logic eyv;
    logic [1:0] es;
  } vec_t;
  vec_t tbl [$];
  assign d = {dat[3], dat[2], dat[1], dat[0]};
  always #5 clock = ~clock;
  stream_mux_rr dut (
    .clock(clock), .reset_n(rst_n), .enable(en), .d_valid(dv), .d_ready(d_ready),
    .d(d), .d_last(dl), .y_valid(y_valid), .y_ready(yr), .y(y), .y_last(y_last), .y_sel(y_sel)
  );
  stream_mux_rr #(.RR_MODE(0)) dut_fp (
    .clock(clock), .reset_n(rst_n), .enable(en), .d_valid(dv), .d_ready(d_ready_fp),
    .d(d), .d_last(dl), .y_valid(y_valid_fp), .y_ready(yr), .y(y_fp), .y_last(y_last_fp), .y_sel(y_sel_fp)
  );
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic int model_grant();
    if (m_lock >= 0) return dv[m_lock] ? m_lock : -1;
    for (int k = 0; k < 4; k++)
      if (dv[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction
  task automatic step();
    int g;
    bit acc;
    #1;
    g = model_grant();
    acc = rst_n && en && g >= 0 && (!m_yv || yr);
    s_ready = d_ready;
    s_rfp = d_ready_fp;
    chk("model_ready", d_ready, acc ? (32'd1 << g) : 32'd0);
    @(posedge clock);
    if (!rst_n) begin
      m_lock = -1; m_ptr = 0; m_yv = 0; m_y = 0; m_yl = 0; m_ys = 0;
    end else if (acc) begin
      m_yv = 1; m_y = dat[g]; m_yl = dl[g]; m_ys = g;
      if (dl[g]) begin
        m_lock = -1;
        m_ptr = (g + 1) % 4;
      end else m_lock = g;
    end else if (yr) m_yv = 0;
    #1;
    s_yv = y_valid; s_ys = y_sel; s_y = y;
    chk("model_yv", y_valid, m_yv);
    chk("model_y", y, m_y);
    chk("model_ylast", y_last, m_yl);
    chk("model_ysel", y_sel, m_ys);
    @(negedge clock);
  endtask
  initial begin
    m_lock = -1; m_ptr = 0; m_yv = 0; m_y = 0; m_yl = 0; m_ys = 0;
    rst_n = 0; en = 1; yr = 1; dv = 4'hF; dl = 4'hF;
    for (int i = 0; i < 4; i++) dat[i] = 32'h1000_0000 + i;
    tbl.push_back('{0, 1, 1, 4'hF, 4'hF, 4'h0, 0, 0});
    tbl.push_back('{0, 1, 1, 4'hF, 4'hF, 4'h0, 0, 0});
    tbl.push_back('{1, 1, 1, 4'hF, 4'hF, 4'h1, 1, 0});
    tbl.push_back('{1, 1, 1, 4'hF, 4'hF, 4'h2, 1, 1});
    tbl.push_back('{1, 1, 1, 4'hF, 4'hF, 4'h4, 1, 2});
    tbl.push_back('{1, 1, 1, 4'hF, 4'hF, 4'h8, 1, 3});
    tbl.push_back('{1, 1, 1, 4'hF, 4'hF, 4'h1, 1, 0});
    tbl.push_back('{1, 1, 1, 4'hB, 4'h9, 4'h2, 1, 1});
    tbl.push_back('{1, 1, 1, 4'hB, 4'h9, 4'h2, 1, 1});
    tbl.push_back('{1, 1, 1, 4'hB, 4'hB, 4'h2, 1, 1});
    tbl.push_back('{1, 1, 1, 4'h9, 4'h9, 4'h8, 1, 3});
    tbl.push_back('{1, 1, 1, 4'h9, 4'h9, 4'h1, 1, 0});
    tbl.push_back('{1, 0, 1, 4'hF, 4'hF, 4'h0, 0, 0});
    tbl.push_back('{1, 1, 1, 4'hF, 4'hF, 4'h2, 1, 1});
    tbl.push_back('{1, 1, 1, 4'h0, 4'hF, 4'h0, 0, 1});
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; yr = tbl[i].yr; dv = tbl[i].dv; dl = tbl[i].dl;
      step();
      chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].er);
      chk($sformatf("tbl%0d_yv", i), s_yv, tbl[i].eyv);
      chk($sformatf("tbl%0d_ysel", i), s_ys, tbl[i].es);
      if (tbl[i].eyv) chk($sformatf("tbl%0d_y", i), s_y, 32'h1000_0000 + tbl[i].es);
      if (!tbl[i].rst_n) chk($sformatf("tbl%0d_rst_y", i), s_y, 0);
    end
    dat[2] = 32'h8000_0000; dv = 4'h4; dl = 4'h4; yr = 1;
    step();
    chk("bp_first_ready", s_ready, 4'h4);
    yr = 0; dv = 4'hB; dl = 4'hF;
    repeat (5) begin
      step();
      chk("bp_ready", s_ready, 4'h0);
      chk("bp_hold_y", s_y, 32'h8000_0000);
      chk("bp_hold_yv", s_yv, 1);
    end
    yr = 1; dv = 4'h0;
    step();
    chk("bp_drain_yv", s_yv, 0);
    dv = 4'h5; dl = 4'h5; dat[0] = 32'h0000_00A0; dat[2] = 32'h0000_00A2;
    repeat (6) begin
      step();
      chk("fp_ready", s_rfp, 4'h1);
      chk("fp_ysel", y_sel_fp, 0);
      chk("fp_yv", y_valid_fp, 1);
      chk("fp_y", y_fp, 32'h0000_00A0);
      chk("fp_ylast", y_last_fp, 1);
    end
    dv = 4'h8; dl = 4'h0;
    repeat (2) step();
    rst_n = 0; dv = 4'h9; dl = 4'h9;
    step();
    rst_n = 1;
    step();
    chk("rstmid_ready", s_ready, 4'h1);
    chk("rstmid_ysel", s_ys, 0);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if (!(dv[i] && !s_ready[i])) begin
          dv[i] = $urandom_range(0, 1);
          dl[i] = $urandom_range(0, 2) != 0;
          dat[i] = $urandom;
        end
      rst_n = $urandom_range(0, 199) != 0;
      en = $urandom_range(0, 9) != 0;
      yr = $urandom_range(0, 9) < 7;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
